// File: rtl/cpu_axi_pkg.sv
// cpu_axi_pkg: shared constants and FSM encodings for the SRAM-like to AXI3 bridge.
package cpu_axi_pkg;
    localparam int INST_ID_DEF = 0;
    localparam int DATA_ID_DEF = 1;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_R    = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_B    = 2'd2;
    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;
endpackage

// File: rtl/cpu_axi_bridge_if.sv
// cpu_sram_if / axi3_if: CPU-side SRAM-like ports and the AXI3 master bus of the bridge.
interface cpu_sram_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              inst_req;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    modport master (
        output inst_req, inst_size, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
    );
    modport slave (
        input  inst_req, inst_size, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
    );
endinterface

interface axi3_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32, parameter int ID_W = 4);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/cpu_axi_bridge_wstrb.sv
// sram_like_wstrb: byte-lane strobe for a 32-bit SRAM-like access from size and low address bits.
module sram_like_wstrb
    import cpu_axi_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_i,
    output logic [3:0] wstrb_o
);
    always_comb
        wstrb_o = size_i == SIZE_BYTE ? 4'b0001 << addr_i :
                  size_i == SIZE_HALF ? 4'b0011 << {addr_i[1], 1'b0} :
                  size_i == SIZE_WORD ? 4'hF : 4'h0;
endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: merges the CPU inst (read-only) and data (read/write) SRAM-like ports into one
// single-beat AXI3 master with one read and one write outstanding.
module cpu_axi_bridge
    import cpu_axi_pkg::*;
#(
    parameter int              ADDR_W  = 32,
    parameter int              DATA_W  = 32,
    parameter int              ID_W    = 4,
    parameter logic [ID_W-1:0] INST_ID = ID_W'(INST_ID_DEF),
    parameter logic [ID_W-1:0] DATA_ID = ID_W'(DATA_ID_DEF)
) (
    input  logic       clk,
    input  logic       resetn,
    cpu_sram_if.slave  cpu,
    axi3_if.master     axi
);
    logic [1:0]          r_state_q, r_state_d, w_state_q, w_state_d;
    logic [ADDR_W-1:0]   r_addr_q, r_addr_d, w_addr_q, w_addr_d;
    logic [1:0]          r_size_q, r_size_d, w_size_q, w_size_d;
    logic [ID_W-1:0]     r_id_q, r_id_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [DATA_W/8-1:0] w_strb_q, w_strb_d, strb;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                r_idle, w_idle, data_busy, d_rd_ok, i_raw;
    logic                data_rd_go, inst_rd_go, data_wr_go, r_done, b_done, aw_all, w_all;
    logic                unused_ok;

    sram_like_wstrb u_wstrb (.size_i(cpu.data_size), .addr_i(cpu.data_addr[1:0]), .wstrb_o(strb));

    assign r_idle = r_state_q == R_IDLE;
    assign w_idle = w_state_q == W_IDLE;
    // Data accesses are strictly serialised so their completions come back in request order.
    assign data_busy  = ~w_idle | (~r_idle & r_id_q == DATA_ID);
    assign d_rd_ok    = cpu.data_req & ~cpu.data_wr & ~data_busy;
    assign data_wr_go = cpu.data_req & cpu.data_wr & ~data_busy;
    // An inst read to a word being written waits for the write response (also if accepted this cycle).
    assign i_raw = (~w_idle & cpu.inst_addr[ADDR_W-1:2] == w_addr_q[ADDR_W-1:2]) |
                   (data_wr_go & cpu.inst_addr[ADDR_W-1:2] == cpu.data_addr[ADDR_W-1:2]);
    assign data_rd_go = r_idle & d_rd_ok;
    assign inst_rd_go = r_idle & cpu.inst_req & ~i_raw & ~d_rd_ok;
    assign r_done = r_state_q == R_R & axi.rvalid;
    assign b_done = w_state_q == W_B & axi.bvalid;
    assign aw_all = aw_done_q | axi.awready;
    assign w_all  = w_done_q | axi.wready;

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_size_d  = r_size_q;
        r_id_d    = r_id_q;
        if (data_rd_go | inst_rd_go) begin
            r_state_d = R_AR;
            r_addr_d  = data_rd_go ? cpu.data_addr : cpu.inst_addr;
            r_size_d  = data_rd_go ? cpu.data_size : cpu.inst_size;
            r_id_d    = data_rd_go ? DATA_ID : INST_ID;
        end
        if (r_state_q == R_AR && axi.arready) r_state_d = R_R;
        if (r_done) r_state_d = R_IDLE;
    end

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_size_d  = w_size_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (data_wr_go) begin
            w_state_d = W_AW;
            w_addr_d  = cpu.data_addr;
            w_size_d  = cpu.data_size;
            w_data_d  = cpu.data_wdata;
            w_strb_d  = strb;
        end
        if (w_state_q == W_AW) begin
            w_state_d = aw_all & w_all ? W_B : W_AW;
            aw_done_d = aw_all & ~w_all;
            w_done_d  = w_all & ~aw_all;
        end
        if (b_done) w_state_d = W_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_size_q  <= '0;
            r_id_q    <= '0;
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_size_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_size_q  <= r_size_d;
            r_id_q    <= r_id_d;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_size_q  <= w_size_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign axi.arid    = r_id_q;
    assign axi.araddr  = r_addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, r_size_q};
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = r_state_q == R_AR;
    assign axi.rready  = r_state_q == R_R;
    assign axi.awid    = DATA_ID;
    assign axi.awaddr  = w_addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, w_size_q};
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 2'd0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = w_state_q == W_AW & ~aw_done_q;
    assign axi.wid     = DATA_ID;
    assign axi.wdata   = w_data_q;
    assign axi.wstrb   = w_strb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = w_state_q == W_AW & ~w_done_q;
    assign axi.bready  = w_state_q == W_B;

    assign cpu.inst_addr_ok = inst_rd_go;
    assign cpu.data_addr_ok = data_rd_go | data_wr_go;
    assign cpu.inst_data_ok = r_done & axi.rid != DATA_ID;
    assign cpu.data_data_ok = (r_done & axi.rid == DATA_ID) | b_done;
    assign cpu.inst_rdata   = axi.rdata;
    assign cpu.data_rdata   = axi.rdata;
    assign unused_ok = ^{axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed checks of arbitration, single-beat AXI handshakes, RAW hold-off and reset.
module tb_cpu_axi_bridge;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_sram_if cpu();
    axi3_if     axi();
    cpu_axi_bridge dut (.clk(clk), .resetn(resetn), .cpu(cpu), .axi(axi));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        cpu.inst_req = 0; cpu.inst_size = 0; cpu.inst_addr = 0;
        cpu.data_req = 0; cpu.data_wr = 0; cpu.data_size = 0; cpu.data_addr = 0; cpu.data_wdata = 0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bid = 0; axi.bresp = 0; axi.bvalid = 0;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 0);
        chk("rst_oks", {cpu.inst_addr_ok, cpu.data_addr_ok, cpu.inst_data_ok, cpu.data_data_ok}, 0);
        nxt(); resetn = 1; nxt();
        // inst-only read, arready after two cycles
        cpu.inst_req = 1; cpu.inst_size = 2; cpu.inst_addr = 32'hBFC00000;
        smp(); chk("i_aok", {cpu.inst_addr_ok, cpu.data_addr_ok}, 2'b10);
        nxt(); cpu.inst_req = 0;
        smp(); chk("ar_fields", {axi.arvalid, axi.arid, axi.araddr, axi.arsize, axi.arlen, axi.arburst},
                   {1'b1, 4'h0, 32'hBFC00000, 3'b010, 8'h0, 2'b01});
        nxt(); smp(); chk("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, 32'hBFC00000});
        nxt(); axi.arready = 1;
        nxt(); axi.arready = 0;
        smp(); chk("rr_wait", {axi.rready, axi.arvalid, cpu.inst_data_ok}, 3'b100);
        nxt(); axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h24080001; axi.rlast = 1;
        smp(); chk("i_dok", {cpu.inst_data_ok, cpu.data_data_ok, cpu.inst_rdata}, {2'b10, 32'h24080001});
        nxt(); axi.rvalid = 0;
        smp(); chk("i_dok_pulse", {cpu.inst_data_ok, axi.rready, axi.arvalid}, 0);
        // simultaneous inst and data reads: data first
        nxt(); cpu.inst_req = 1; cpu.inst_addr = 32'hBFC00004;
        cpu.data_req = 1; cpu.data_wr = 0; cpu.data_size = 2; cpu.data_addr = 32'h80000010;
        smp(); chk("arb_aok", {cpu.data_addr_ok, cpu.inst_addr_ok}, 2'b10);
        nxt(); cpu.data_req = 0; axi.arready = 1;
        smp(); chk("arb_ar", {axi.arvalid, axi.arid, axi.araddr, cpu.inst_addr_ok}, {1'b1, 4'h1, 32'h80000010, 1'b0});
        nxt(); axi.arready = 0; axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'h11223344;
        smp(); chk("arb_ddok", {cpu.data_data_ok, cpu.inst_data_ok, cpu.inst_addr_ok, cpu.data_rdata},
                   {3'b100, 32'h11223344});
        nxt(); axi.rvalid = 0;
        smp(); chk("arb_iaok", cpu.inst_addr_ok, 1);
        nxt(); cpu.inst_req = 0; axi.arready = 1;
        smp(); chk("arb_iar", {axi.arvalid, axi.arid, axi.araddr}, {1'b1, 4'h0, 32'hBFC00004});
        nxt(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h8C020000;
        smp(); chk("arb_idok", {cpu.inst_data_ok, cpu.data_data_ok, cpu.inst_rdata}, {2'b10, 32'h8C020000});
        nxt(); axi.rvalid = 0;
        // byte store, awready before wready
        cpu.data_req = 1; cpu.data_wr = 1; cpu.data_size = 0; cpu.data_addr = 32'h80000003; cpu.data_wdata = 32'hAB;
        smp(); chk("sb_aok", cpu.data_addr_ok, 1);
        nxt(); cpu.data_req = 0; cpu.data_wr = 0; axi.awready = 1;
        smp(); chk("sb_aw", {axi.awvalid, axi.wvalid, axi.awid, axi.wid, axi.awaddr, axi.awsize, axi.wstrb, axi.wlast},
                   {1'b1, 1'b1, 4'h1, 4'h1, 32'h80000003, 3'b000, 4'b1000, 1'b1});
        chk("sb_wdata", axi.wdata, 32'hAB);
        nxt(); axi.awready = 0;
        smp(); chk("sb_aw_drop", {axi.awvalid, axi.wvalid, axi.bready}, 3'b010);
        nxt(); axi.wready = 1;
        smp(); chk("sb_w", {axi.awvalid, axi.wvalid}, 2'b01);
        nxt(); axi.wready = 0;
        smp(); chk("sb_b_wait", {axi.bready, axi.wvalid, cpu.data_data_ok}, 3'b100);
        nxt(); axi.bvalid = 1;
        smp(); chk("sb_dok", cpu.data_data_ok, 1);
        nxt(); axi.bvalid = 0;
        smp(); chk("sb_dok_pulse", {cpu.data_data_ok, axi.bready}, 0);
        // halfword store held in W_B; RAW on same word, other word passes
        nxt(); cpu.data_req = 1; cpu.data_wr = 1; cpu.data_size = 1; cpu.data_addr = 32'h80001002;
        cpu.data_wdata = 32'hBEEF0000; axi.awready = 1; axi.wready = 1;
        smp(); chk("raw_waok", cpu.data_addr_ok, 1);
        nxt(); cpu.data_req = 0; cpu.data_wr = 0;
        smp(); chk("hw_wstrb", {axi.awvalid, axi.wvalid, axi.wstrb, axi.wdata}, {2'b11, 4'b1100, 32'hBEEF0000});
        nxt(); axi.awready = 0; axi.wready = 0; cpu.inst_req = 1; cpu.inst_addr = 32'h80001000;
        smp(); chk("raw_block", {cpu.inst_addr_ok, axi.bready, axi.awvalid, axi.wvalid}, 4'b0100);
        nxt(); cpu.data_req = 1; cpu.data_wr = 0; cpu.data_addr = 32'h80001000;
        smp(); chk("raw_dblock", {cpu.inst_addr_ok, cpu.data_addr_ok}, 0);
        nxt(); cpu.data_req = 0; cpu.inst_addr = 32'h80002000;
        smp(); chk("raw_pass", cpu.inst_addr_ok, 1);
        nxt(); cpu.inst_req = 0; axi.arready = 1;
        smp(); chk("raw_par_ar", {axi.arvalid, axi.araddr, axi.bready}, {1'b1, 32'h80002000, 1'b1});
        nxt(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h00C0FFEE;
        smp(); chk("raw_par_r", {cpu.inst_data_ok, cpu.data_data_ok, cpu.inst_rdata}, {2'b10, 32'h00C0FFEE});
        nxt(); axi.rvalid = 0; cpu.inst_req = 1; cpu.inst_addr = 32'h80001000;
        smp(); chk("raw_block2", cpu.inst_addr_ok, 0);
        nxt(); axi.bvalid = 1;
        smp(); chk("raw_b", {cpu.data_data_ok, cpu.inst_addr_ok}, 2'b10);
        nxt(); axi.bvalid = 0;
        smp(); chk("raw_release", {cpu.inst_addr_ok, cpu.data_data_ok}, 2'b10);
        nxt(); cpu.inst_req = 0;
        smp(); chk("raw_rel_ar", {axi.arvalid, axi.araddr}, {1'b1, 32'h80001000});
        axi.arready = 1;
        nxt(); axi.arready = 0;
        // asynchronous reset while waiting for R
        smp(); chk("rst_pre", axi.rready, 1);
        #2 resetn = 0;
        #2 chk("rst_async", {axi.rready, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready}, 0);
        nxt(); nxt(); resetn = 1; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hDEAD0000;
        smp(); chk("rst_no_dok", {cpu.inst_data_ok, cpu.data_data_ok, axi.rready}, 0);
        nxt(); axi.rvalid = 0; cpu.data_req = 1; cpu.data_wr = 0; cpu.data_addr = 32'h80000020;
        smp(); chk("post_rst_aok", {cpu.data_addr_ok, cpu.inst_addr_ok}, 2'b10);
        nxt(); cpu.data_req = 0;
        smp(); chk("post_rst_ar", {axi.arvalid, axi.arid, axi.araddr}, {1'b1, 4'h1, 32'h80000020});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
